// File: rtl/or1200_opmux_pkg.sv
// Shared constants and select-code definitions for the N-operand,
// N-stage forwarding operand mux.
package or1200_opmux_pkg;

  // Select code width: one code each for rf and imm, plus one per forwarding stage.
  function automatic int sel_width(input int nfwd);
    return $clog2(nfwd + 2);
  endfunction

  localparam int SEL_RF   = 0;
  localparam int SEL_IMM  = 1;
  localparam int SEL_FWD0 = 2;

  // Select code at the default depth of three forwarding stages.
  localparam int SELW_DEF = sel_width(3);
  typedef logic [SELW_DEF-1:0] sel_code_t;

endpackage

// File: rtl/or1200_opmux_lane.sv
// One operand lane: forward-match priority encoder, immediate override
// and the save-once EX capture register.
module or1200_opmux_lane
  import or1200_opmux_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NFWD = 3,
  parameter int SELW = sel_width(NFWD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_freeze,
  input  logic               ex_freeze,
  input  logic               hazard_stall,
  input  logic [AW-1:0]      src_addr,
  input  logic               src_en,
  input  logic [DW-1:0]      rf_data,
  input  logic [DW-1:0]      imm,
  input  logic               imm_en,
  input  logic               imm_sel,
  input  logic [NFWD-1:0]    fwd_we,
  input  logic [NFWD*AW-1:0] fwd_addr,
  input  logic [NFWD*DW-1:0] fwd_data,
  input  logic [NFWD-1:0]    fwd_rdy,
  output logic               lane_hazard,
  output logic [DW-1:0]      operand,
  output logic [SELW-1:0]    sel_o
);

  logic            hit;
  logic            win_rdy;
  logic [DW-1:0]   mux_data;
  logic [SELW-1:0] mux_sel;
  logic            saved;

  // Pick the youngest matching stage; the immediate overrides all forwarding.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    hit      = 1'b0;
    win_rdy  = 1'b1;
    mux_data = rf_data;
    mux_sel  = SELW'(SEL_RF);
    // Walk oldest to youngest so the youngest match is the last one written.
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (src_en && fwd_we[k] && (src_addr != '0) &&
          (fwd_addr[k*AW +: AW] == src_addr)) begin
        hit      = 1'b1;
        win_rdy  = fwd_rdy[k];
        mux_data = fwd_data[k*DW +: DW];
        mux_sel  = SELW'(SEL_FWD0 + k);
      end
    end
    if (imm_en && imm_sel) begin
      hit      = 1'b0;
      mux_data = imm;
      mux_sel  = SELW'(SEL_IMM);
    end
  end

  assign lane_hazard = hit && !win_rdy;

  // Save-once capture: a value taken while ID is frozen survives one unfreeze cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      operand <= '0;
      sel_o   <= SELW'(SEL_RF);
      saved   <= 1'b0;
    end else if (!ex_freeze && !hazard_stall) begin
      if (id_freeze) begin
        if (!saved) begin
          operand <= mux_data;
          sel_o   <= mux_sel;
          saved   <= 1'b1;
        end
      end else if (saved) begin
        saved <= 1'b0;
      end else begin
        operand <= mux_data;
        sel_o   <= mux_sel;
      end
    end
  end

endmodule

// File: rtl/or1200_opmux_fwdn.sv
// Parametrised operand mux: NOPS lanes with NFWD-stage forwarding and a
// shared load-use stall that also blocks every lane's capture.
module or1200_opmux_fwdn
  import or1200_opmux_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NOPS = 2,
  parameter int NFWD = 3,
  localparam int SELW = sel_width(NFWD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_freeze,
  input  logic                 ex_freeze,
  input  logic [NOPS*AW-1:0]   src_addr,
  input  logic [NOPS-1:0]      src_en,
  input  logic [NOPS*DW-1:0]   rf_data,
  input  logic [DW-1:0]        imm,
  input  logic                 imm_sel,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*DW-1:0]   fwd_data,
  input  logic [NFWD-1:0]      fwd_rdy,
  output logic [NOPS*DW-1:0]   operand,
  output logic [NOPS*SELW-1:0] sel_o,
  output logic                 hazard_stall
);

  logic [NOPS-1:0] lane_hazard;

  assign hazard_stall = |lane_hazard;

  // One lane per operand; only operand 1 can take the immediate.
  for (genvar i = 0; i < NOPS; i++) begin : g_lane
    or1200_opmux_lane #(
      .DW   (DW),
      .AW   (AW),
      .NFWD (NFWD),
      .SELW (SELW)
    ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_freeze    (id_freeze),
      .ex_freeze    (ex_freeze),
      .hazard_stall (hazard_stall),
      .src_addr     (src_addr[i*AW +: AW]),
      .src_en       (src_en[i]),
      .rf_data      (rf_data[i*DW +: DW]),
      .imm          (imm),
      .imm_en       ((i == 1) ? 1'b1 : 1'b0),
      .imm_sel      (imm_sel),
      .fwd_we       (fwd_we),
      .fwd_addr     (fwd_addr),
      .fwd_data     (fwd_data),
      .fwd_rdy      (fwd_rdy),
      .lane_hazard  (lane_hazard[i]),
      .operand      (operand[i*DW +: DW]),
      .sel_o        (sel_o[i*SELW +: SELW])
    );
  end

endmodule

// File: tb/tb_or1200_opmux_fwdn.sv
// Scoreboard bench for or1200_opmux_fwdn at default parameters
// (DW=32, AW=5, NOPS=2, NFWD=3, SELW=3).
module tb_or1200_opmux_fwdn;
  import or1200_opmux_pkg::*;

  localparam sel_code_t RF   = sel_code_t'(SEL_RF);
  localparam sel_code_t IMM  = sel_code_t'(SEL_IMM);
  localparam sel_code_t FWD0 = sel_code_t'(SEL_FWD0);
  localparam sel_code_t FWD1 = sel_code_t'(SEL_FWD0 + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_freeze = 1'b0;
  logic        ex_freeze = 1'b0;
  logic [9:0]  src_addr;
  logic [1:0]  src_en = 2'b11;
  logic [63:0] rf_data;
  logic [31:0] imm = '0;
  logic        imm_sel = 1'b0;
  logic [2:0]  fwd_we = '0;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  logic [2:0]  fwd_rdy = 3'b111;
  logic [63:0] operand;
  logic [5:0]  sel_o;
  logic        hazard_stall;

  logic [4:0]  sa [2] = '{5'd0, 5'd0};
  logic [31:0] rf [2] = '{32'h0, 32'h0};
  logic [4:0]  fa [3] = '{5'd0, 5'd0, 5'd0};
  logic [31:0] fd [3] = '{32'h0, 32'h0, 32'h0};

  assign src_addr = {sa[1], sa[0]};
  assign rf_data  = {rf[1], rf[0]};
  assign fwd_addr = {fa[2], fa[1], fa[0]};
  assign fwd_data = {fd[2], fd[1], fd[0]};

  or1200_opmux_fwdn dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_freeze    (id_freeze),
    .ex_freeze    (ex_freeze),
    .src_addr     (src_addr),
    .src_en       (src_en),
    .rf_data      (rf_data),
    .imm          (imm),
    .imm_sel      (imm_sel),
    .fwd_we       (fwd_we),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data),
    .fwd_rdy      (fwd_rdy),
    .operand      (operand),
    .sel_o        (sel_o),
    .hazard_stall (hazard_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op0;
    sel_code_t   s0;
    logic [31:0] op1;
    sel_code_t   s1;
    logic        hz;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // Inputs are already driven for this cycle; queue what the next edge must produce.
  task automatic step(input string tag, input logic [31:0] o0, input sel_code_t s0,
                      input logic [31:0] o1, input sel_code_t s1, input logic hz);
    sb.push_back('{op0: o0, s0: s0, op1: o1, s1: s1, hz: hz, tag: tag});
    @(negedge clk);
  endtask

  // Monitor: just after each edge, compare the registered outputs and the stall.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".op0"}, operand[31:0], e.op0);
        check({e.tag, ".sel0"}, 32'(sel_o[2:0]), 32'(e.s0));
        check({e.tag, ".op1"}, operand[63:32], e.op1);
        check({e.tag, ".sel1"}, 32'(sel_o[5:3]), 32'(e.s1));
        check({e.tag, ".hazard"}, 32'(hazard_stall), 32'(e.hz));
      end
    end
  end

  initial begin
    int waited;
    #2;
    check("reset.operand", operand[31:0], 32'h0);
    check("reset.sel", 32'(sel_o), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // No forwarding: both lanes take rf data.
    sa = '{5'd3, 5'd4}; rf = '{32'h11, 32'h44};
    step("nomatch", 32'h11, RF, 32'h44, RF, 1'b0);

    // Stages 0 and 2 both hold r7: youngest wins.
    sa[0] = 5'd7; fwd_we = 3'b111; fwd_rdy = 3'b111;
    fa = '{5'd7, 5'd9, 5'd7}; fd = '{32'hA0, 32'hB0, 32'hC0};
    step("prio", 32'hA0, FWD0, 32'h44, RF, 1'b0);

    // Address 0 never forwards even when stages target r0.
    sa[0] = 5'd0; rf[0] = 32'h12; fa = '{5'd0, 5'd9, 5'd0};
    step("r0", 32'h12, RF, 32'h44, RF, 1'b0);

    // Only the middle stage matches.
    sa[0] = 5'd9;
    step("stage1", 32'hB0, FWD1, 32'h44, RF, 1'b0);

    // Youngest match not ready, older ready: stall, and every lane holds.
    sa[0] = 5'd7; fa = '{5'd7, 5'd9, 5'd7}; fwd_rdy = 3'b110; rf[1] = 32'h45;
    step("loaduse", 32'hB0, FWD1, 32'h44, RF, 1'b1);

    // Load result arrives.
    fwd_rdy = 3'b111; fd[0] = 32'h55;
    step("loaddone", 32'h55, FWD0, 32'h45, RF, 1'b0);

    // Save-once: capture under id_freeze, hold, hold one unfreeze cycle, recapture.
    fwd_we = '0; sa[0] = 5'd3; rf[0] = 32'h22; id_freeze = 1'b1;
    step("save", 32'h22, RF, 32'h45, RF, 1'b0);
    rf = '{32'h33, 32'h46};
    step("savehold", 32'h22, RF, 32'h45, RF, 1'b0);
    id_freeze = 1'b0;
    step("unfreeze1", 32'h22, RF, 32'h45, RF, 1'b0);
    step("unfreeze2", 32'h33, RF, 32'h46, RF, 1'b0);

    // ex_freeze holds everything while inputs toggle.
    ex_freeze = 1'b1;
    rf[0] = 32'h99;
    step("exf0", 32'h33, RF, 32'h46, RF, 1'b0);
    imm_sel = 1'b1; imm = 32'h5;
    step("exf1", 32'h33, RF, 32'h46, RF, 1'b0);
    imm_sel = 1'b0; fwd_we = 3'b001; fa[0] = 5'd3; fwd_rdy = 3'b110;
    step("exf2", 32'h33, RF, 32'h46, RF, 1'b1);
    fwd_we = '0; fwd_rdy = 3'b111; id_freeze = 1'b1;
    step("exf3", 32'h33, RF, 32'h46, RF, 1'b0);
    ex_freeze = 1'b0; id_freeze = 1'b0;

    // Immediate on operand 1 overrides a matching forward.
    sa = '{5'd3, 5'd7}; rf[0] = 32'h34; fwd_we = 3'b111;
    fa = '{5'd7, 5'd9, 5'd7}; fd = '{32'h77, 32'hB0, 32'hC0};
    imm_sel = 1'b1; imm = 32'hFFFF_FFF0;
    step("imm", 32'h34, RF, 32'hFFFF_FFF0, IMM, 1'b0);

    // Immediate ignores an unready forward on its own address.
    fwd_rdy = 3'b110; imm = 32'h1234;
    step("immnohz", 32'h34, RF, 32'h1234, IMM, 1'b0);

    // src_en=0 forces the rf path with no hazard.
    imm_sel = 1'b0; sa = '{5'd7, 5'd4}; src_en = 2'b10; rf = '{32'h66, 32'h47};
    step("srcen", 32'h66, RF, 32'h47, RF, 1'b0);

    // Capture under id_freeze, then reset mid-cycle.
    src_en = 2'b11; fwd_we = '0; fwd_rdy = 3'b111; sa[0] = 5'd3;
    rf[0] = 32'hDEAD_BEEF; id_freeze = 1'b1;
    step("deadbeef", 32'hDEAD_BEEF, RF, 32'h47, RF, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst.op0", operand[31:0], 32'h0);
    check("async_rst.op1", operand[63:32], 32'h0);
    check("async_rst.sel", 32'(sel_o), 32'h0);

    // Saved flags were cleared: still frozen, yet the first edge captures.
    @(negedge clk);
    rst_n = 1'b1; rf = '{32'h70, 32'h71};
    step("postrst", 32'h70, RF, 32'h71, RF, 1'b0);

    waited = 0;
    while (sb.size() > 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    #2;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
